icp_modes: RTL

Second-generation Intcode processor core with parameter modes, a stream I/O handshake and the full comparison/branch opcode set. It is parametrised in data and address width. It drives the same 4-port shared data memory as the first-generation core: port 0 is read/write, ports 1-3 are read-only in practice. Input and output values travel on valid/ready streams to the host harness.

---
 rtl/icp_pkg.sv | 52 +++++
 rtl/icp_decode.sv | 31 +++
 rtl/icp_modes.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/icp_pkg.sv
// Shared constants, state encoding and instruction-length helper for the
// parameter-mode Intcode core.
package icp_pkg;

  // Per-port memory operation encoding
  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_READ  = 2'd1;
  localparam logic [1:0] MEM_WRITE = 2'd2;

  // Opcodes (JUMP is the legacy whole-word 100, not a mod-100 opcode)
  localparam logic [6:0] OPC_ADD  = 7'd1;
  localparam logic [6:0] OPC_MUL  = 7'd2;
  localparam logic [6:0] OPC_IN   = 7'd3;
  localparam logic [6:0] OPC_OUT  = 7'd4;
  localparam logic [6:0] OPC_JIT  = 7'd5;
  localparam logic [6:0] OPC_JIF  = 7'd6;
  localparam logic [6:0] OPC_LT   = 7'd7;
  localparam logic [6:0] OPC_EQ   = 7'd8;
  localparam logic [6:0] OPC_HALT = 7'd99;
  localparam logic [6:0] OPC_JUMP = 7'd100;

  // Parameter modes
  localparam logic [3:0] MODE_POS = 4'd0;
  localparam logic [3:0] MODE_IMM = 4'd1;

  // Instruction words at or above this value cannot be decoded
  localparam int WORD_LIMIT = 100000;

  typedef enum logic [3:0] {
    S_FETCH,
    S_F_WAIT,
    S_DECODE,
    S_O_WAIT,
    S_EXEC,
    S_IN,
    S_OUT,
    S_HALTED,
    S_FAULT
  } state_t;

  // Words occupied by an instruction; 0 marks an unknown opcode
  function automatic logic [2:0] instr_len(input logic [6:0] opc);
    case (opc)
      OPC_ADD, OPC_MUL, OPC_LT, OPC_EQ: return 3'd4;
      OPC_JIT, OPC_JIF:                 return 3'd3;
      OPC_IN, OPC_OUT, OPC_JUMP:        return 3'd2;
      OPC_HALT:                         return 3'd1;
      default:                          return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/icp_decode.sv
// Combinational instruction-word splitter: opcode, three mode digits and
// an out-of-range flag. Only the low 17 bits feed the dividers because any
// word that decodes legally fits there.
module icp_decode
  import icp_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] word_i,
  output logic [6:0]        opcode_o,
  output logic [3:0]        mode_o [3],
  output logic              illegal_o
);

  logic [16:0] low_w;
  logic [16:0] digits [3];

  assign low_w     = word_i[16:0];
  assign illegal_o = word_i[DATA_W-1] || (word_i >= DATA_W'(WORD_LIMIT));
  assign opcode_o  = (word_i == DATA_W'(100)) ? OPC_JUMP : 7'(low_w % 17'd100);
  assign digits[0] = low_w / 17'd100;

  // Peel one decimal digit per parameter position
  for (genvar gi = 0; gi < 3; gi++) begin : g_mode
    assign mode_o[gi] = 4'(digits[gi] % 17'd10);
    if (gi < 2) begin : g_next
      assign digits[gi+1] = digits[gi] / 17'd10;
    end
  end

endmodule

// File: rtl/icp_modes.sv
// Second-generation Intcode core: parameter modes, valid/ready stream I/O,
// comparison and branch opcodes, driving a 4-port shared data memory.
module icp_modes
  import icp_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [1:0]        o_op   [4],
  output logic [ADDR_W-1:0] o_addr [4],
  input  logic [DATA_W-1:0] i_data [4],
  output logic [DATA_W-1:0] o_data [4],
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  input  logic              i_out_ready,
  output logic              o_halted,
  output logic              o_fault
);

  // A signed word is a usable address only if it is non-negative and fits
  function automatic logic addr_ok(input logic [DATA_W-1:0] v);
    return v[DATA_W-1:ADDR_W] == '0;
  endfunction

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [6:0]        opc_q;
  logic [1:0]        imm_q;
  logic [DATA_W-1:0] p_q [2];
  logic [ADDR_W-1:0] p3_addr_q;
  logic [1:0]        op_q   [4];
  logic [ADDR_W-1:0] addr_q [4];
  logic [DATA_W-1:0] wdata_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              halted_q;
  logic              fault_q;

  // Decode-time signals derived from the freshly fetched words
  logic [6:0]        dec_opc;
  logic [3:0]        dec_mode [3];
  logic              dec_illegal;
  logic [2:0]        dec_len;
  logic              dec_alu;
  logic              dec_branch;
  logic [2:0]        used;
  logic [2:0]        wr_pos;
  logic [2:0]        src_pos;
  logic [2:0]        rd_en;
  logic [2:0]        p_bad;
  logic              dec_fault;

  // Execute-time operand values and results
  logic [DATA_W-1:0] op_val [2];
  logic [DATA_W-1:0] alu_res;
  logic              take_jump;

  icp_decode #(.DATA_W(DATA_W)) u_decode (
    .word_i   (i_data[0]),
    .opcode_o (dec_opc),
    .mode_o   (dec_mode),
    .illegal_o(dec_illegal)
  );

  assign dec_len    = instr_len(dec_opc);
  assign dec_alu    = (dec_opc == OPC_ADD) || (dec_opc == OPC_MUL) ||
                      (dec_opc == OPC_LT)  || (dec_opc == OPC_EQ);
  assign dec_branch = (dec_opc == OPC_JIT) || (dec_opc == OPC_JIF);

  // Per-parameter role and legality: mode digit range, write-target rules
  // and address range of every operand that will actually be dereferenced
  for (genvar gi = 0; gi < 3; gi++) begin : g_param
    assign used[gi]    = (dec_opc != OPC_JUMP) && (3'(gi + 1) < dec_len);
    assign wr_pos[gi]  = ((gi == 2) && dec_alu) || ((gi == 0) && (dec_opc == OPC_IN));
    assign src_pos[gi] = ((gi < 2) && (dec_alu || dec_branch)) ||
                         ((gi == 0) && (dec_opc == OPC_OUT));
    assign rd_en[gi]   = src_pos[gi] && (dec_mode[gi] == MODE_POS);
    assign p_bad[gi]   = (used[gi] && (dec_mode[gi] > MODE_IMM)) ||
                         (wr_pos[gi] && ((dec_mode[gi] != MODE_POS) || !addr_ok(i_data[gi+1]))) ||
                         (rd_en[gi] && !addr_ok(i_data[gi+1]));
  end

  assign dec_fault = dec_illegal || (dec_len == 3'd0) || (|p_bad) ||
                     ((dec_opc == OPC_JUMP) && !addr_ok(i_data[1]));

  // Operand value: memory read-back for position mode, literal otherwise
  for (genvar gi = 0; gi < 2; gi++) begin : g_operand
    assign op_val[gi] = imm_q[gi] ? p_q[gi] : i_data[gi+1];
  end

  assign take_jump = (opc_q == OPC_JIT) ? (op_val[0] != '0) : (op_val[0] == '0);

  // Arithmetic and comparison result destined for P3
  always_comb begin
    case (opc_q)
      OPC_ADD: alu_res = op_val[0] + op_val[1];
      OPC_MUL: alu_res = op_val[0] * op_val[1];
      OPC_LT:  alu_res = DATA_W'($signed(op_val[0]) < $signed(op_val[1]));
      OPC_EQ:  alu_res = DATA_W'(op_val[0] == op_val[1]);
      default: alu_res = '0;
    endcase
  end

  // Core state machine; every output is driven from a register here
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      opc_q       <= '0;
      imm_q       <= '0;
      p_q[0]      <= '0;
      p_q[1]      <= '0;
      p3_addr_q   <= '0;
      wdata_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        op_q[i]   <= MEM_NONE;
        addr_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          // Any write from EXEC/IN is visible to memory during this cycle
          for (int i = 0; i < 4; i++) begin
            op_q[i]   <= MEM_READ;
            addr_q[i] <= pc_q + ADDR_W'(i);
          end
          state_q <= S_F_WAIT;
        end
        S_F_WAIT: state_q <= S_DECODE;
        S_DECODE: begin
          opc_q     <= dec_opc;
          imm_q[0]  <= (dec_mode[0] == MODE_IMM);
          imm_q[1]  <= (dec_mode[1] == MODE_IMM);
          p_q[0]    <= i_data[1];
          p_q[1]    <= i_data[2];
          p3_addr_q <= i_data[3][ADDR_W-1:0];
          op_q[0]   <= MEM_NONE;
          for (int i = 0; i < 3; i++) begin
            op_q[i+1]   <= (rd_en[i] && !dec_fault) ? MEM_READ : MEM_NONE;
            addr_q[i+1] <= i_data[i+1][ADDR_W-1:0];
          end
          if (dec_fault) begin
            fault_q <= 1'b1;
            state_q <= S_FAULT;
          end else begin
            state_q <= S_O_WAIT;
          end
        end
        S_O_WAIT: state_q <= S_EXEC;
        S_EXEC: begin
          for (int i = 0; i < 4; i++) op_q[i] <= MEM_NONE;
          state_q <= S_FETCH;
          case (opc_q)
            OPC_ADD, OPC_MUL, OPC_LT, OPC_EQ: begin
              op_q[0]   <= MEM_WRITE;
              addr_q[0] <= p3_addr_q;
              wdata_q   <= alu_res;
              pc_q      <= pc_q + ADDR_W'(4);
            end
            OPC_IN: begin
              in_ready_q <= 1'b1;
              state_q    <= S_IN;
            end
            OPC_OUT: begin
              out_valid_q <= 1'b1;
              out_data_q  <= op_val[0];
              state_q     <= S_OUT;
            end
            OPC_JIT, OPC_JIF: begin
              if (!take_jump) begin
                pc_q <= pc_q + ADDR_W'(3);
              end else if (addr_ok(op_val[1])) begin
                pc_q <= op_val[1][ADDR_W-1:0];
              end else begin
                fault_q <= 1'b1;
                state_q <= S_FAULT;
              end
            end
            OPC_JUMP: pc_q <= p_q[0][ADDR_W-1:0];
            OPC_HALT: begin
              halted_q <= 1'b1;
              state_q  <= S_HALTED;
            end
            default: begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end
          endcase
        end
        S_IN: begin
          if (i_in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            op_q[0]    <= MEM_WRITE;
            addr_q[0]  <= p_q[0][ADDR_W-1:0];
            wdata_q    <= i_in_data;
            pc_q       <= pc_q + ADDR_W'(2);
            state_q    <= S_FETCH;
          end
        end
        S_OUT: begin
          if (i_out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_q + ADDR_W'(2);
            state_q     <= S_FETCH;
          end
        end
        default: begin
          // HALTED and FAULT park with every port idle
          for (int i = 0; i < 4; i++) op_q[i] <= MEM_NONE;
        end
      endcase
    end
  end

  // Only port 0 ever carries write data
  for (genvar gi = 0; gi < 4; gi++) begin : g_port
    assign o_op[gi]   = op_q[gi];
    assign o_addr[gi] = addr_q[gi];
    assign o_data[gi] = (gi == 0) ? wdata_q : '0;
  end

  assign o_in_ready  = in_ready_q;
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;
  assign o_halted    = halted_q;
  assign o_fault     = fault_q;

endmodule
